sha256_padder: RTL and testbench

- Upstream feeder for the SHA-256 hasher.
- Accepts a message as a stream of 32-bit big-endian words and assembles 512-bit blocks of 16 words.
- Appends standard SHA-256 padding: byte 0x80, zero fill, and the 64-bit message bit-length.
- Presents each block to the hasher with first-block and last-block flags over a valid/ready handshake.

---
 rtl/sha256_padder_pkg.sv | 22 ++
 rtl/sha256_last_word_mask.sv | 24 ++
 rtl/sha256_padder.sv | 200 ++++++++++++++++++++
 tb/tb_sha256_padder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_padder_pkg.sv
// Shared types and constants for the SHA-256 message padder.
package sha256_padder_pkg;

   typedef logic [31:0]       uint32_t;
   typedef logic [0:15][31:0] block_t;

   localparam uint32_t SHA256_PAD_WORD = 32'h8000_0000;

   typedef enum logic [2:0] {
      ST_FILL    = 3'd0,
      ST_PADMARK = 3'd1,
      ST_PAD     = 3'd2,
      ST_LENGTH  = 3'd3,
      ST_EMIT    = 3'd4
   } pad_state_e;

   // Reverse the byte order of a word (little-endian input support).
   function automatic uint32_t byte_swap(input uint32_t w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/sha256_last_word_mask.sv
// Masks the final message word to its valid bytes and inserts the 0x80
// marker directly after them. Zero valid bytes yields the bare marker word;
// four (or more) valid bytes pass the word through unchanged.
module sha256_last_word_mask
   import sha256_padder_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [2:0]  bytes_i,
   output logic [31:0] word_o
);

   // Select the masked/marked word from the valid byte count.
   always_comb begin
      word_o = word_i;
      case (bytes_i)
         3'd0:    word_o = SHA256_PAD_WORD;
         3'd1:    word_o = {word_i[31:24], 24'h80_0000};
         3'd2:    word_o = {word_i[31:16], 16'h8000};
         3'd3:    word_o = {word_i[31:8], 8'h80};
         default: word_o = word_i;
      endcase
   end

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs 32-bit message words into 512-bit blocks,
// appends 0x80, zero fill and the 64-bit bit length, and hands blocks to the
// hasher over a valid/ready handshake.
// Optional build macro SHA256_PADDER_BYTESWAP_EN: byte-reverse wordIn before
// storage (little-endian input; lastBytesIn then counts from [7:0] upward).
//
// Handshake: a word moves on the rising edge where validIn & readyOut are
// both high; a block moves on the rising edge where validOut &
// readyForBlockIn are both high. While validOut is high, blockOut and the
// block flags do not change.
module sha256_padder
   import sha256_padder_pkg::*;
#(
   parameter int LEN_WIDTH = 64
) (
   input  logic              clk,
   input  logic              rstN,
   input  logic              validIn,
   input  logic [31:0]       wordIn,
   input  logic              lastIn,
   input  logic [2:0]        lastBytesIn,
   output logic              readyOut,
   output logic [0:15][31:0] blockOut,
   output logic              validOut,
   output logic              firstBlockOut,
   output logic              lastBlockOut,
   input  logic              readyForBlockIn,
   output logic [2:0]        dbgStateOut
);

   pad_state_e           state_q, state_d;
   pad_state_e           next_q, next_d;     // state to resume after Emit
   logic [3:0]           idx_q, idx_d;
   block_t               block_q, block_d;
   logic [LEN_WIDTH-1:0] bitlen_q, bitlen_d;
   logic                 armed_q, armed_d;   // next emitted block is first
   logic                 first_q, first_d;
   logic                 last_q, last_d;
   logic                 alive_q;            // holds readyOut low during reset

   logic [31:0]          word_s;
   logic [31:0]          masked_s;
   logic [2:0]           bytes_eff;
   logic [63:0]          len64;
   logic                 accept;
   logic                 go_emit;
   logic                 place_mark;

`ifdef SHA256_PADDER_BYTESWAP_EN
   assign word_s = byte_swap(wordIn);
`else
   assign word_s = wordIn;
`endif

   // Out-of-range byte counts behave as a full word.
   assign bytes_eff = (lastBytesIn > 3'd4) ? 3'd4 : lastBytesIn;
   assign len64     = 64'(bitlen_q);
   assign accept    = validIn && readyOut;

   sha256_last_word_mask u_mask (
      .word_i  (word_s),
      .bytes_i (bytes_eff),
      .word_o  (masked_s)
   );

   // Next-state logic: block assembly, padding sequence and emit handshake.
   always_comb begin
      state_d    = state_q;
      next_d     = next_q;
      idx_d      = idx_q;
      block_d    = block_q;
      bitlen_d   = bitlen_q;
      armed_d    = armed_q;
      first_d    = first_q;
      last_d     = last_q;
      go_emit    = 1'b0;
      place_mark = 1'b0;

      case (state_q)
         ST_FILL: begin
            if (accept) begin
               block_d[idx_q] = lastIn ? masked_s : word_s;
               if (!lastIn) begin
                  bitlen_d = bitlen_q + LEN_WIDTH'(32);
                  if (idx_q == 4'd15) begin
                     go_emit = 1'b1;
                     next_d  = ST_FILL;
                  end else begin
                     idx_d = idx_q + 4'd1;
                  end
               end else if (bytes_eff == 3'd4) begin
                  // Full final word: the marker goes into the following slot.
                  bitlen_d = bitlen_q + LEN_WIDTH'(32);
                  if (idx_q == 4'd15) begin
                     go_emit = 1'b1;
                     next_d  = ST_PADMARK;
                  end else begin
                     idx_d   = idx_q + 4'd1;
                     state_d = ST_PADMARK;
                  end
               end else begin
                  // Marker already merged into this word by the mask.
                  bitlen_d   = bitlen_q + LEN_WIDTH'({bytes_eff, 3'b000});
                  place_mark = 1'b1;
               end
            end
         end
         ST_PADMARK: begin
            block_d[idx_q] = SHA256_PAD_WORD;
            place_mark     = 1'b1;
         end
         ST_PAD: begin
            block_d[idx_q] = 32'h0;
            if (idx_q == 4'd13) begin
               idx_d   = 4'd14;
               state_d = ST_LENGTH;
            end else if (idx_q == 4'd15) begin
               // Marker landed in word 14/15: length needs a fresh block.
               go_emit = 1'b1;
               next_d  = ST_PAD;
            end else begin
               idx_d = idx_q + 4'd1;
            end
         end
         ST_LENGTH: begin
            block_d[14] = len64[63:32];
            block_d[15] = len64[31:0];
            last_d      = 1'b1;
            go_emit     = 1'b1;
            next_d      = ST_FILL;
         end
         ST_EMIT: begin
            if (readyForBlockIn) begin
               idx_d   = 4'd0;
               first_d = 1'b0;
               state_d = next_q;
               if (last_q) begin
                  bitlen_d = '0;
                  armed_d  = 1'b1;
                  last_d   = 1'b0;
               end
            end
         end
         default: state_d = ST_FILL;
      endcase

      // The word at idx_q now holds the 0x80 marker; decide what follows.
      if (place_mark) begin
         if (idx_q == 4'd15) begin
            go_emit = 1'b1;
            next_d  = ST_PAD;
         end else if (idx_q == 4'd13) begin
            idx_d   = 4'd14;
            state_d = ST_LENGTH;
         end else begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_PAD;
         end
      end

      if (go_emit) begin
         state_d = ST_EMIT;
         first_d = armed_q;
         armed_d = 1'b0;
      end
   end

   // State and datapath registers; reset aborts any message in flight.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q  <= ST_FILL;
         next_q   <= ST_FILL;
         idx_q    <= 4'd0;
         block_q  <= '0;
         bitlen_q <= '0;
         armed_q  <= 1'b1;
         first_q  <= 1'b0;
         last_q   <= 1'b0;
         alive_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         next_q   <= next_d;
         idx_q    <= idx_d;
         block_q  <= block_d;
         bitlen_q <= bitlen_d;
         armed_q  <= armed_d;
         first_q  <= first_d;
         last_q   <= last_d;
         alive_q  <= 1'b1;
      end
   end

   assign readyOut      = alive_q && (state_q == ST_FILL);
   assign validOut      = (state_q == ST_EMIT);
   assign blockOut      = block_q;
   assign firstBlockOut = first_q;
   assign lastBlockOut  = last_q;
   assign dbgStateOut   = state_q;

endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench for sha256_padder: directed messages, expected blocks
// queued at stimulus time and compared by an independent block monitor.
module tb_sha256_padder;

   logic              clk;
   logic              rstN;
   logic              validIn;
   logic [31:0]       wordIn;
   logic              lastIn;
   logic [2:0]        lastBytesIn;
   logic              readyOut;
   logic [0:15][31:0] blockOut;
   logic              validOut;
   logic              firstBlockOut;
   logic              lastBlockOut;
   logic              readyForBlockIn;
   logic [2:0]        dbgStateOut;

   int checks = 0;
   int errors = 0;

   // {first, last, block}
   logic [513:0] exp_q[$];

   sha256_padder #(.LEN_WIDTH(64)) dut (
      .clk             (clk),
      .rstN            (rstN),
      .validIn         (validIn),
      .wordIn          (wordIn),
      .lastIn          (lastIn),
      .lastBytesIn     (lastBytesIn),
      .readyOut        (readyOut),
      .blockOut        (blockOut),
      .validOut        (validOut),
      .firstBlockOut   (firstBlockOut),
      .lastBlockOut    (lastBlockOut),
      .readyForBlockIn (readyForBlockIn),
      .dbgStateOut     (dbgStateOut)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   function automatic logic [31:0] fmt(input logic [31:0] w);
`ifdef SHA256_PADDER_BYTESWAP_EN
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
      return w;
`endif
   endfunction

   function automatic logic [31:0] data_word(input int i);
      return 32'hA500_0000 | 32'(i);
   endfunction

   task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic push_exp(input logic first, input logic last, input logic [0:15][31:0] blk);
      exp_q.push_back({first, last, blk});
   endtask

   // Drive one word and hold it until the padder takes it (bounded).
   task automatic send_word(input logic [31:0] w, input logic last, input logic [2:0] nb);
      int  n;
      bit  done;
      n = 0;
      done = 0;
      validIn     = 1'b1;
      wordIn      = fmt(w);
      lastIn      = last;
      lastBytesIn = nb;
      while (!done) begin
         @(negedge clk);
         if (readyOut) begin
            @(posedge clk);
            #1;
            done = 1;
         end else begin
            n++;
            if (n > 200) begin
               checks++;
               errors++;
               $display("FAIL send_timeout: word %h not accepted within 200 cycles", w);
               done = 1;
            end
         end
      end
      validIn     = 1'b0;
      lastIn      = 1'b0;
      lastBytesIn = 3'd0;
   endtask

   // Wait until every expected block has been observed (bounded).
   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      #1;
      check32({name, "_drain"}, 32'(exp_q.size()), 32'd0);
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      logic [513:0] exp;
      if (rstN && validOut && readyForBlockIn) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_block: first=%0b last=%0b got %h expected none",
                     firstBlockOut, lastBlockOut, blockOut);
         end else begin
            exp = exp_q.pop_front();
            if ({firstBlockOut, lastBlockOut, blockOut} !== exp) begin
               errors++;
               $display("FAIL block: got first=%0b last=%0b %h expected first=%0b last=%0b %h",
                        firstBlockOut, lastBlockOut, blockOut, exp[513], exp[512], exp[511:0]);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [0:15][31:0] blk;
      logic [0:15][31:0] snap;
      logic [1:0]        snap_flags;
      int                n;

      rstN            = 1'b0;
      validIn         = 1'b0;
      wordIn          = 32'h0;
      lastIn          = 1'b0;
      lastBytesIn     = 3'd0;
      readyForBlockIn = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      check32("rst_validOut", 32'(validOut), 32'd0);
      check32("rst_readyOut", 32'(readyOut), 32'd0);
      check32("rst_first", 32'(firstBlockOut), 32'd0);
      check32("rst_last", 32'(lastBlockOut), 32'd0);
      check32("rst_block_or", 32'(|blockOut), 32'd0);
      rstN = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check32("ready_after_reset", 32'(readyOut), 32'd1);
      @(posedge clk);
      #1;

      // "abc"
      blk = '0; blk[0] = 32'h6162_6380; blk[15] = 32'h18;
      push_exp(1, 1, blk);
      send_word(32'h6162_6300, 1, 3'd3);
      wait_idle("abc");

      // Empty message: data discarded, bare marker
      blk = '0; blk[0] = 32'h8000_0000;
      push_exp(1, 1, blk);
      send_word(32'hDEAD_BEEF, 1, 3'd0);
      wait_idle("empty");

      // 56 bytes: marker at word 14, length spills into a second block
      blk = '0;
      for (int i = 0; i < 14; i++) blk[i] = data_word(i);
      blk[14] = 32'h8000_0000;
      push_exp(1, 0, blk);
      blk = '0; blk[15] = 32'h1C0;
      push_exp(0, 1, blk);
      for (int i = 0; i < 14; i++) send_word(data_word(i), i == 13, 3'd4);
      wait_idle("len56");

      // 64 bytes: full data block, then marker + length block
      blk = '0;
      for (int i = 0; i < 16; i++) blk[i] = data_word(i);
      push_exp(1, 0, blk);
      blk = '0; blk[0] = 32'h8000_0000; blk[15] = 32'h200;
      push_exp(0, 1, blk);
      for (int i = 0; i < 16; i++) send_word(data_word(i), i == 15, 3'd4);
      check32("full_block_latency", 32'(validOut), 32'd1);
      wait_idle("len64");

      // 55 bytes: marker merged into word 13, length fits in the same block
      blk = '0;
      for (int i = 0; i < 13; i++) blk[i] = data_word(i);
      blk[13] = 32'hA500_0080; blk[15] = 32'h1B8;
      push_exp(1, 1, blk);
      for (int i = 0; i < 14; i++) send_word(data_word(i), i == 13, (i == 13) ? 3'd3 : 3'd4);
      wait_idle("len55");

      // 61 bytes: marker merged into word 15, length in a fresh block
      blk = '0;
      for (int i = 0; i < 15; i++) blk[i] = data_word(i);
      blk[15] = 32'hA580_0000;
      push_exp(1, 0, blk);
      blk = '0; blk[15] = 32'h1E8;
      push_exp(0, 1, blk);
      for (int i = 0; i < 16; i++) send_word(data_word(i), i == 15, (i == 15) ? 3'd1 : 3'd4);
      wait_idle("len61");

      // Back-pressure: hasher stalls 10 cycles while a new word is pending
      readyForBlockIn = 1'b0;
      blk = '0; blk[0] = 32'h6162_6364; blk[1] = 32'h6566_6780; blk[15] = 32'h38;
      push_exp(1, 1, blk);
      blk = '0; blk[0] = 32'h6162_6380; blk[15] = 32'h18;
      push_exp(1, 1, blk);
      send_word(32'h6162_6364, 0, 3'd0);
      send_word(32'h6566_6700, 1, 3'd3);
      fork
         send_word(32'h6162_6300, 1, 3'd3);
      join_none
      n = 0;
      while (!validOut && n < 50) begin
         @(negedge clk);
         n++;
      end
      check32("stall_valid_seen", 32'(validOut), 32'd1);
      snap       = blockOut;
      snap_flags = {firstBlockOut, lastBlockOut};
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checks++;
         if (!validOut || readyOut || blockOut !== snap ||
             {firstBlockOut, lastBlockOut} !== snap_flags) begin
            errors++;
            $display("FAIL stall_hold: cycle %0d valid=%0b ready=%0b flags=%b block %h expected valid=1 ready=0 flags=%b block %h",
                     c, validOut, readyOut, {firstBlockOut, lastBlockOut}, blockOut, snap_flags, snap);
         end
      end
      readyForBlockIn = 1'b1;
      wait fork;
      wait_idle("stall");

      // Reset mid-message: everything cleared, next message unaffected
      for (int i = 0; i < 5; i++) send_word(data_word(i), 0, 3'd0);
      rstN = 1'b0;
      #2;
      check32("midrst_validOut", 32'(validOut), 32'd0);
      check32("midrst_readyOut", 32'(readyOut), 32'd0);
      check32("midrst_first", 32'(firstBlockOut), 32'd0);
      check32("midrst_last", 32'(lastBlockOut), 32'd0);
      check32("midrst_block_or", 32'(|blockOut), 32'd0);
      check32("midrst_state", 32'(dbgStateOut), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rstN = 1'b1;
      @(posedge clk);
      #1;
      blk = '0; blk[0] = 32'h6162_6380; blk[15] = 32'h18;
      push_exp(1, 1, blk);
      send_word(32'h6162_6300, 1, 3'd3);
      wait_idle("after_reset");

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global guard against a hung run.
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded 200000 time units, expected completion");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
